morph_window_5x5: RTL and testbench
===================================

// Module: morph_window_5x5
// PURPOSE
//  Builds the 5x5 neighbourhood of every pixel of a raster-scanned 8-bit frame, feeding
//  the 5x5 dilate/erode kernels directly. Four line buffers plus a 5x5 register array.
//  Out-of-image taps are forced to PAD_VAL. One window per input pixel (full W*H output).
//  A flush phase drains the last two rows and columns after the final input pixel.
// PARAMETERS
//  IMG_W    640  pixels per line (>=5)
//  IMG_H    480  lines per frame (>=5)
//  PAD_VAL  8'h00  border value; 0 is neutral for dilation, 8'hFF for erosion
// PORTS
//  clk        in   1    single clock, all logic on posedge
//  rst_n      in   1    synchronous, active-low reset
//  in_pix     in   8    input pixel, raster order
//  in_valid   in   1    in_pix valid
//  in_sof     in   1    qualifies first pixel of a frame (sampled with in_valid)
//  in_ready   out  1    block accepts in_pix this cycle
//  win        out  200  window; win[8k+7:8k] = wk, k = 5*row+col, w0 top-left, w12 centre
//  out_valid  out  1    win valid this cycle (1-cycle pulse per window)
//  out_eof    out  1    with out_valid on window of centre (IMG_H-1, IMG_W-1)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, in_ready=1, out_valid=0, out_eof=0, win=0,
//    all counters 0. Line-buffer contents are don't-care (masked by padding).
//  - Accept = in_valid & in_ready. States IDLE -> ACTIVE -> FLUSH -> IDLE.
//  - IDLE: in_ready=1; accepts without in_sof are dropped. Accept with in_sof -> ACTIVE,
//    the pixel is stream position 0.
//  - ACTIVE: each accept is one "tick": pixel shifts into bottom row of array, line
//    buffers shift column-wise (read-before-write at in_col). in_col wraps at IMG_W-1,
//    in_row increments on wrap. Tick on position IMG_W*IMG_H-1 -> FLUSH.
//  - FLUSH: in_ready=0; one tick per cycle injecting PAD_VAL, exactly 2*IMG_W+2 ticks,
//    then IDLE (in_ready=1 the cycle after the last flush tick).
//  - Output: the tick at stream position p >= 2*IMG_W+2 produces the window centred on
//    position p-(2*IMG_W+2); out_valid/win are registered, asserted the cycle after
//    that tick. Total out_valid pulses per frame = IMG_W*IMG_H exactly.
//  - Padding: output centre counters (oc, orow) drive masks; tap (dr,dc), dr,dc in
//    -2..2, is PAD_VAL when orow+dr or oc+dc is outside [0,IMG_H-1]/[0,IMG_W-1].
//    Wrap-around tail of the previous line in the array must never leak.
//  - Backpressure: none on output; downstream is combinational and always consumes.
//  - in_sof accepted while ACTIVE: current frame abandoned, no further windows of it
//    (no out_eof); counters restart with this pixel as position 0. in_sof is ignored
//    in FLUSH (in_ready=0 there).
//  - in_valid gaps in ACTIVE: no tick, array and counters hold, out_valid=0.
//  - Reset mid-frame: all above reset values next cycle; partial frame discarded.
//  - Counter widths $clog2(IMG_W), $clog2(IMG_H), flush counter $clog2(2*IMG_W+3).
// STRUCTURE
//  - Shared header morph_defs.vh: pixel width 8, window size 5, tap index macro
//    (5*row+col), state encodings IDLE/ACTIVE/FLUSH, default PAD_VAL constants.
//  - Sub-module morph_line_buffer (depth IMG_W, 8 bit, sync read-before-write);
//    instantiated 4x, chained: row r output feeds row r+1 input.
//  - Top holds FSM, input/output counters, 5x5 array, padding mux, output register.
// TESTING (IMG_W=8, IMG_H=6, unless noted)
//  1 Ramp frame pix=row*8+col, in_valid=1 continuous -> 48 windows, first at cycle
//    18+1 after sof accept; window centre (2,3): w0=8'd1, w12=8'd19, w24=8'd37.
//  2 Same frame, PAD_VAL=0 -> centre (0,0): w0..w11 and cols 0..1 = 0, w12=0, w24=8'd18;
//    centre (5,7): out_eof=1, rows 3-4 and cols 3-4 = 0.
//  3 Random in_valid gaps (50%) -> identical window sequence to test 1, in_ready=0 for
//    exactly 18 cycles after last accept.
//  4 in_sof re-asserted at pixel 20 of frame 1 -> no out_eof for frame 1, frame 2
//    completes with 48 windows matching golden model.
//  5 rst_n=0 for 1 cycle mid-ACTIVE -> out_valid=0, in_ready=1 next cycle; non-sof
//    pixels dropped until next sof.
//  6 Chained with 5x5 dilate, random frames, PAD_VAL=0 -> matches software max-filter.

Source files
------------

// File: rtl/morph_window_5x5_pkg.sv
// Shared constants, state encoding and tap indexing for the 5x5 morphology window.
package morph_window_5x5_pkg;

   localparam int PIX_W    = 8;
   localparam int WIN_N    = 5;
   localparam int WIN_BITS = PIX_W * WIN_N * WIN_N;

   localparam logic [PIX_W-1:0] PAD_DILATE = 8'h00;
   localparam logic [PIX_W-1:0] PAD_ERODE  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } morph_state_t;

   function automatic int tapIdx(input int row, input int col);
      return WIN_N * row + col;
   endfunction

endpackage

// File: rtl/morph_window_5x5_if.sv
// Pixel stream in, window stream out; the window block sits on the slave side.
interface morph_window_5x5_if;
   import morph_window_5x5_pkg::*;

   logic [PIX_W-1:0]    in_pix;
   logic                in_valid;
   logic                in_sof;
   logic                in_ready;
   logic [WIN_BITS-1:0] win;
   logic                out_valid;
   logic                out_eof;

   modport master (
      output in_pix, in_valid, in_sof,
      input  in_ready, win, out_valid, out_eof
   );

   modport slave (
      input  in_pix, in_valid, in_sof,
      output in_ready, win, out_valid, out_eof
   );

endinterface

// File: rtl/morph_window_5x5_line_buffer.sv
// One image line of storage; the old value at addr is presented while the new one is written.
module morph_line_buffer #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign dout = mem[addr];

   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= din;
      end
   end

endmodule

// File: rtl/morph_window_5x5.sv
// Raster 5x5 neighbourhood generator: four chained line buffers feed a 5x5 register array,
// border taps are replaced by PAD_VAL, and a flush phase drains the last two rows.
module morph_window_5x5 import morph_window_5x5_pkg::*; #(
   parameter int               IMG_W   = 640,
   parameter int               IMG_H   = 480,
   parameter logic [PIX_W-1:0] PAD_VAL = PAD_DILATE
) (
   input logic              clk,
   input logic              rst_n,
   morph_window_5x5_if.slave bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(2*IMG_W+3);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W-1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H-1);
   localparam logic [FW-1:0] LEAD       = FW'(2*IMG_W+2);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(2*IMG_W+1);

   morph_state_t state, nextState;
   logic [CW-1:0] inCol, oc, lbAddr;
   logic [RW-1:0] inRow, orow;
   logic [FW-1:0] warm, flushCnt;
   logic inReady, tick, restart, emit;
   logic [PIX_W-1:0] tickPix;
   logic [3:0][PIX_W-1:0] lbIn, lbOut;
   logic [4:0][4:0][PIX_W-1:0] arr, nextArr;
   logic [4:0] rowOk, colOk;
   logic [WIN_BITS-1:0] winNext, winReg;
   logic outValid, outEof;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // A tick is one stream position; a sof tick restarts the frame at position 0.
   always_comb begin
      nextState = state;
      inReady   = 1'b0;
      tick      = 1'b0;
      restart   = 1'b0;
      tickPix   = PAD_VAL;
      case (state)
         IDLE: begin
            inReady = 1'b1;
            if (bus.in_valid && bus.in_sof) begin
               tick      = 1'b1;
               restart   = 1'b1;
               tickPix   = bus.in_pix;
               nextState = ACTIVE;
            end
         end
         ACTIVE: begin
            inReady = 1'b1;
            if (bus.in_valid) begin
               tick    = 1'b1;
               tickPix = bus.in_pix;
               if (bus.in_sof) restart = 1'b1;
               else if (inCol == COL_LAST && inRow == ROW_LAST) nextState = FLUSH;
            end
         end
         FLUSH: begin
            tick = 1'b1;
            if (flushCnt == FLUSH_LAST) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      emit   = tick && !restart && (state == FLUSH || warm == LEAD);
      lbAddr = restart ? '0 : inCol;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inCol    <= '0;
         inRow    <= '0;
         warm     <= '0;
         flushCnt <= '0;
         oc       <= '0;
         orow     <= '0;
      end else if (tick) begin
         if (restart) begin
            inCol    <= CW'(1);
            inRow    <= '0;
            warm     <= FW'(1);
            flushCnt <= '0;
            oc       <= '0;
            orow     <= '0;
         end else begin
            if (inCol == COL_LAST) begin
               inCol <= '0;
               if (state == ACTIVE) inRow <= inRow + 1'b1;
            end else begin
               inCol <= inCol + 1'b1;
            end
            if (warm != LEAD) warm <= warm + 1'b1;
            flushCnt <= (state == FLUSH) ? flushCnt + 1'b1 : '0;
            if (emit) begin
               if (oc == COL_LAST) begin
                  oc   <= '0;
                  orow <= orow + 1'b1;
               end else begin
                  oc <= oc + 1'b1;
               end
            end
         end
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_lb
      morph_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb (
         .clk (clk),
         .en  (tick),
         .addr(lbAddr),
         .din (lbIn[i]),
         .dout(lbOut[i])
      );
   end

   // Bottom array row takes the new pixel; row r above it takes the line buffer (3-r) deep.
   always_comb begin
      lbIn[0] = tickPix;
      for (int i = 1; i < 4; i++) lbIn[i] = lbOut[i-1];
      nextArr = arr;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) nextArr[r][c] = arr[r][c+1];
         nextArr[r][4] = (r == 4) ? tickPix : lbOut[3-r];
      end
   end

   always_ff @(posedge clk) begin
      if (tick) arr <= nextArr;
   end

   // Masks come from the output centre, so stale tails of earlier lines or frames never leak.
   always_comb begin
      rowOk   = '0;
      colOk   = '0;
      winNext = '0;
      for (int r = 0; r < 5; r++) begin
         rowOk[r] = (int'(orow) + r >= 2) && (int'(orow) + r - 2 <= IMG_H - 1);
         colOk[r] = (int'(oc) + r >= 2) && (int'(oc) + r - 2 <= IMG_W - 1);
      end
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            winNext[PIX_W*tapIdx(r, c) +: PIX_W] = (rowOk[r] && colOk[c]) ? nextArr[r][c] : PAD_VAL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outValid <= 1'b0;
         outEof   <= 1'b0;
         winReg   <= '0;
      end else begin
         outValid <= emit;
         outEof   <= emit && oc == COL_LAST && orow == ROW_LAST;
         if (emit) winReg <= winNext;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.win       = winReg;
   assign bus.out_valid = outValid;
   assign bus.out_eof   = outEof;

endmodule

// File: tb/tb_morph_window_5x5.sv
// Scoreboard bench for morph_window_5x5 on an 8x6 frame with zero padding.
module tb_morph_window_5x5;
   import morph_window_5x5_pkg::*;

   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;

   typedef struct packed {
      logic [WIN_BITS-1:0] win;
      logic                eof;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cycle = 0;
   int checks = 0;
   int errors = 0;
   exp_t expQ[$];
   logic [7:0] frame [N];
   logic [WIN_BITS-1:0] capWin [N];
   logic capEof [N];
   int outCount = 0;
   int firstValidCycle = -1;
   int sofCycle = 0;
   int lowCnt = 0;

   morph_window_5x5_if mwIf ();

   morph_window_5x5 #(.IMG_W(W), .IMG_H(H), .PAD_VAL(8'h00)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (mwIf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Every presented window is matched against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mwIf.out_valid === 1'b1) begin
         if (outCount == 0) firstValidCycle = cycle;
         if (outCount < N) begin
            capWin[outCount] = mwIf.win;
            capEof[outCount] = mwIf.out_eof;
         end
         outCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_window: got win=%h eof=%b, required no window", mwIf.win, mwIf.out_eof);
         end else begin
            e = expQ.pop_front();
            if (mwIf.win !== e.win || mwIf.out_eof !== e.eof) begin
               errors++;
               $display("[TB] FAIL window: got win=%h eof=%b, required win=%h eof=%b",
                        mwIf.win, mwIf.out_eof, e.win, e.eof);
            end
         end
      end
   end

   function automatic logic [WIN_BITS-1:0] modelWin(input int r0, input int c0);
      logic [WIN_BITS-1:0] w = '0;
      for (int dr = -2; dr <= 2; dr++) begin
         for (int dc = -2; dc <= 2; dc++) begin
            if (r0 + dr >= 0 && r0 + dr < H && c0 + dc >= 0 && c0 + dc < W)
               w[8*(5*(dr+2) + dc + 2) +: 8] = frame[(r0+dr)*W + c0 + dc];
         end
      end
      return w;
   endfunction

   task automatic pushFrame(input int nCentres);
      exp_t e;
      for (int q = 0; q < nCentres; q++) begin
         e.win = modelWin(q / W, q % W);
         e.eof = (q == N - 1);
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] pix, input logic sof, input int gap);
      int waitCnt = 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      mwIf.in_pix   = pix;
      mwIf.in_sof   = sof;
      mwIf.in_valid = 1'b1;
      @(negedge clk);
      while (mwIf.in_ready !== 1'b1 && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout: got in_ready=%b, required 1", mwIf.in_ready);
      end
      @(posedge clk);
      #1;
      mwIf.in_valid = 1'b0;
      mwIf.in_sof   = 1'b0;
   endtask

   task automatic drainQueue(input string name);
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      checkOutput(name, expQ.size(), 0);
   endtask

   task automatic sendFrame(input int count, input bit gaps);
      for (int p = 0; p < count; p++)
         applyStimulus(frame[p], p == 0, (gaps && p != 0) ? int'($urandom_range(0, 1)) : 0);
   endtask

   initial begin
      mwIf.in_pix   = '0;
      mwIf.in_valid = 1'b0;
      mwIf.in_sof   = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_in_ready", mwIf.in_ready, 1);
      checkOutput("reset_out_valid", mwIf.out_valid, 0);
      checkOutput("reset_out_eof", mwIf.out_eof, 0);
      checkOutput("reset_win_zero", mwIf.win == '0, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Ramp frame, continuous input, plus hand-computed taps and border windows.
      $display("[TB] ramp frame, continuous");
      for (int p = 0; p < N; p++) frame[p] = 8'(p);
      pushFrame(N);
      outCount = 0;
      sofCycle = cycle;
      sendFrame(N, 1'b0);
      drainQueue("ramp_drain");
      checkOutput("ramp_window_count", outCount, N);
      checkOutput("first_window_latency", firstValidCycle - sofCycle, 19);
      checkOutput("c23_w0", capWin[19][7:0], 1);
      checkOutput("c23_w12", capWin[19][103:96], 19);
      checkOutput("c23_w24", capWin[19][199:192], 37);
      checkOutput("c00_top_pad", capWin[0][95:0] == '0, 1);
      checkOutput("c00_w12", capWin[0][103:96], 0);
      checkOutput("c00_w13", capWin[0][111:104], 1);
      checkOutput("c00_w24", capWin[0][199:192], 18);
      checkOutput("c57_eof", capEof[N-1], 1);
      checkOutput("c56_no_eof", capEof[N-2], 0);
      checkOutput("c57_bottom_pad", capWin[N-1][199:120] == '0, 1);
      checkOutput("c57_w13_pad", capWin[N-1][111:104], 0);
      checkOutput("c57_w12", capWin[N-1][103:96], 47);
      checkOutput("c57_w0", capWin[N-1][7:0], 29);

      // Same ramp with random valid gaps; flush must hold in_ready low 18 cycles.
      $display("[TB] ramp frame, random gaps");
      pushFrame(N);
      sendFrame(N, 1'b1);
      lowCnt = 0;
      @(negedge clk);
      while (mwIf.in_ready !== 1'b1 && lowCnt < 100) begin
         lowCnt++;
         @(negedge clk);
      end
      checkOutput("flush_ready_low", lowCnt, 2*W + 2);
      @(posedge clk);
      #1;
      drainQueue("gaps_drain");

      // Frame abandoned by a new sof at pixel 20.
      $display("[TB] sof restart at pixel 20");
      for (int p = 0; p < N; p++) frame[p] = 8'($urandom_range(0, 255));
      pushFrame(2);
      sendFrame(20, 1'b0);
      for (int p = 0; p < N; p++) frame[p] = 8'($urandom_range(0, 255));
      pushFrame(N);
      sendFrame(N, 1'b0);
      drainQueue("restart_drain");

      // Reset in mid-frame, then stray pixels without sof are dropped.
      $display("[TB] reset mid-frame");
      for (int p = 0; p < N; p++) frame[p] = 8'($urandom_range(0, 255));
      pushFrame(7);
      sendFrame(25, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_out_valid", mwIf.out_valid, 0);
      checkOutput("post_reset_in_ready", mwIf.in_ready, 1);
      @(posedge clk);
      #1;
      for (int p = 0; p < 10; p++) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 0);
      for (int p = 0; p < N; p++) frame[p] = 8'($urandom_range(0, 255));
      pushFrame(N);
      sendFrame(N, 1'b0);
      drainQueue("post_reset_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
